// File: rtl/game2048_pkg.sv
// Shared definitions for the 2048 keyboard front end: PS/2 scan-code set 2
// constants, direction bus bit positions, the make/break prefix FSM states
// and a helper that maps an extended scan code onto the direction bus.
package game2048_pkg;

    // Scan-code set 2 prefixes and the keys this block recognises
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;  // extended
    localparam logic [7:0] SC_DOWN  = 8'h72;  // extended
    localparam logic [7:0] SC_LEFT  = 8'h6B;  // extended
    localparam logic [7:0] SC_RIGHT = 8'h74;  // extended
    localparam logic [7:0] SC_S     = 8'h1B;  // normal

    // Bit positions on the 4-bit direction bus
    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;

    // Prefix FSM: tracks E0 (extended) and F0 (break) prefixes
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } prefix_state_t;

    // One-hot direction mask for an extended code; zero if not an arrow key
    function automatic logic [3:0] ext_dir_mask(input logic [7:0] code);
        logic [3:0] mask;
        mask = 4'b0000;
        case (code)
            SC_UP:    mask[DIR_UP]    = 1'b1;
            SC_DOWN:  mask[DIR_DOWN]  = 1'b1;
            SC_LEFT:  mask[DIR_LEFT]  = 1'b1;
            SC_RIGHT: mask[DIR_RIGHT] = 1'b1;
            default:  mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ps2_direction_decoder_if.sv
// Key-level bus from the PS/2 direction decoder to the game controller.
// The decoder drives it through the master modport, control reads it through
// the slave modport.
interface ps2_direction_decoder_if;

    logic [3:0] direction;    // [3] up, [2] down, [1] left, [0] right
    logic       start;        // S key held
    logic       key_event;    // one-cycle pulse per recognised make
    logic       frame_error;  // one-cycle pulse per discarded frame

    modport master (
        output direction,
        output start,
        output key_event,
        output frame_error
    );

    modport slave (
        input direction,
        input start,
        input key_event,
        input frame_error
    );

endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 receive framer: synchronises the keyboard pins, glitch-filters the
// keyboard clock, samples data on filtered falling edges and assembles
// 11-bit frames (start, 8 data LSB first, odd parity, stop).
// A watchdog aborts a frame whose clock stalls mid-way.
// Optional feature macro: PS2_PARITY_CHECK_EN enables parity/stop checking,
// frame_err_o pulses on bad frames and on watchdog aborts.
module ps2_rx_frame #(
    parameter int FILTER_LEN      = 8,
    parameter int WATCHDOG_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] byte_data_o,
    output logic       byte_valid_o,
    output logic       frame_err_o,
    output logic       wd_abort_o
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [WW-1:0] WD_LAST   = WW'(WATCHDOG_CYCLES - 1);

    logic [1:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic          filt_q;
    logic [FW-1:0] filt_cnt_q;
    logic [3:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic [WW-1:0] wd_cnt_q;
    logic          byte_valid_q;
    logic          wd_abort_q;
    logic          ps2_clk_s;
    logic          ps2_dat_s;
    logic          fall_edge;

    assign ps2_clk_s = clk_sync_q[1];
    assign ps2_dat_s = dat_sync_q[1];

    // The filtered clock drops this cycle: it is high, the synchronised pin
    // is low and this is the FILTER_LEN-th consecutive low cycle.
    assign fall_edge = filt_q && !ps2_clk_s && (filt_cnt_q == FILT_LAST);

    // Two-flop synchronisers; reset to the idle-high bus level
    always_ff @(posedge clock) begin
        if (!resetn) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
        end
    end

    // Saturating glitch filter: accept a new clock level only after it has
    // been stable for FILTER_LEN cycles; any bounce back restarts the count
    always_ff @(posedge clock) begin
        if (!resetn) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
        end else if (ps2_clk_s == filt_q) begin
            filt_cnt_q <= '0;
        end else if (filt_cnt_q == FILT_LAST) begin
            filt_q     <= ps2_clk_s;
            filt_cnt_q <= '0;
        end else begin
            filt_cnt_q <= filt_cnt_q + 1'b1;
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    logic parity_q;
    logic frame_err_q;
`endif

    // Bit counter, shift register, watchdog and end-of-frame pulses
    always_ff @(posedge clock) begin
        if (!resetn) begin
            bit_cnt_q    <= 4'd0;
            shift_q      <= 8'h00;
            wd_cnt_q     <= '0;
            byte_valid_q <= 1'b0;
            wd_abort_q   <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_q     <= 1'b0;
            frame_err_q  <= 1'b0;
`endif
        end else begin
            byte_valid_q <= 1'b0;
            wd_abort_q   <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            frame_err_q  <= 1'b0;
`endif
            if (fall_edge) begin
                // An edge always restarts the watchdog, even on its last cycle
                wd_cnt_q <= '0;
                if (bit_cnt_q == 4'd0) begin
                    // A start bit sampled high is line noise: stay put silently
                    if (!ps2_dat_s) begin
                        bit_cnt_q <= 4'd1;
                    end
                end else if (bit_cnt_q <= 4'd8) begin
                    shift_q   <= {ps2_dat_s, shift_q[7:1]};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end else if (bit_cnt_q == 4'd9) begin
`ifdef PS2_PARITY_CHECK_EN
                    parity_q  <= ps2_dat_s;
`endif
                    bit_cnt_q <= 4'd10;
                end else begin
                    // Stop bit: the frame is complete
                    bit_cnt_q <= 4'd0;
`ifdef PS2_PARITY_CHECK_EN
                    if ((^{parity_q, shift_q}) && ps2_dat_s) begin
                        byte_valid_q <= 1'b1;
                    end else begin
                        frame_err_q  <= 1'b1;
                    end
`else
                    byte_valid_q <= 1'b1;
`endif
                end
            end else if (bit_cnt_q != 4'd0) begin
                if (wd_cnt_q == WD_LAST) begin
                    // Keyboard clock stalled mid-frame: drop the partial frame
                    bit_cnt_q  <= 4'd0;
                    wd_cnt_q   <= '0;
                    wd_abort_q <= 1'b1;
`ifdef PS2_PARITY_CHECK_EN
                    frame_err_q <= 1'b1;
`endif
                end else begin
                    wd_cnt_q <= wd_cnt_q + 1'b1;
                end
            end else begin
                wd_cnt_q <= '0;
            end
        end
    end

    assign byte_data_o  = shift_q;
    assign byte_valid_o = byte_valid_q;
    assign wd_abort_o   = wd_abort_q;
`ifdef PS2_PARITY_CHECK_EN
    assign frame_err_o  = frame_err_q;
`else
    assign frame_err_o  = 1'b0;
`endif

endmodule

// File: rtl/ps2_direction_decoder.sv
// PS/2 keyboard front end for the 2048 top level. Received scan-code set 2
// bytes drive a make/break prefix FSM that maintains held levels for the
// arrow keys (direction bus) and the S key (start), plus a key_event pulse
// on every make of a recognised key.
// Optional feature macro: PS2_PARITY_CHECK_EN (implemented in ps2_rx_frame).
module ps2_direction_decoder #(
    parameter int FILTER_LEN      = 8,
    parameter int WATCHDOG_CYCLES = 50000
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           PS2_CLK,
    input  logic                           PS2_DAT,
    ps2_direction_decoder_if.master        keys
);

    import game2048_pkg::*;

    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rx_err;
    logic          rx_abort;
    logic [3:0]    ext_mask;
    logic          is_s_key;

    prefix_state_t state_q, state_d;
    logic [3:0]    direction_q, direction_d;
    logic          start_q, start_d;
    logic          key_event_q, key_event_d;

    ps2_rx_frame #(
        .FILTER_LEN      (FILTER_LEN),
        .WATCHDOG_CYCLES (WATCHDOG_CYCLES)
    ) u_rx (
        .clock        (clock),
        .resetn       (resetn),
        .ps2_clk_i    (PS2_CLK),
        .ps2_dat_i    (PS2_DAT),
        .byte_data_o  (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_err_o  (rx_err),
        .wd_abort_o   (rx_abort)
    );

    assign ext_mask = ext_dir_mask(rx_byte);
    assign is_s_key = (rx_byte == SC_S);

    // Prefix state register
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Prefix decoding and held-key updates; only a received byte advances it,
    // a discarded or aborted frame forgets any pending prefix
    always_comb begin
        state_d     = state_q;
        direction_d = direction_q;
        start_d     = start_q;
        key_event_d = 1'b0;
        if (rx_abort || rx_err) begin
            state_d = ST_IDLE;
        end else if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_byte == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (rx_byte == SC_BREAK) begin
                        state_d = ST_BRK;
                    end else if (is_s_key) begin
                        start_d     = 1'b1;
                        key_event_d = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (rx_byte == SC_BREAK) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        // Typematic repeats re-pulse key_event on a held arrow
                        if (ext_mask != 4'b0000) begin
                            direction_d = direction_q | ext_mask;
                            key_event_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    if (is_s_key) begin
                        start_d = 1'b0;
                    end
                    state_d = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    direction_d = direction_q & ~ext_mask;
                    state_d     = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output registers: held levels and the make pulse
    always_ff @(posedge clock) begin
        if (!resetn) begin
            direction_q <= 4'b0000;
            start_q     <= 1'b0;
            key_event_q <= 1'b0;
        end else begin
            direction_q <= direction_d;
            start_q     <= start_d;
            key_event_q <= key_event_d;
        end
    end

    assign keys.direction   = direction_q;
    assign keys.start       = start_q;
    assign keys.key_event   = key_event_q;
    assign keys.frame_error = rx_err;

endmodule
